// File: rtl/rv32i_ctrl_alu_dmem.sv
// rv32i_ctrl_alu_dmem
//   Control decoder, ALU and word-addressed data memory for a single-cycle
//   RV32I core. Everything except the memory write is combinational.
//
// Ports
//   clk, rst              clock (memory writes on rising edge), async active-high reset
//   opcode/func3/func7    instruction fields
//   rs1, rs2, sign_ext    register read data and sign-extended immediate
//   init_done             0: init port owns the memory write; 1: store path owns it
//   init_w_addr/dat/enb   preload write port (byte address)
//   debug_addr            word index for the debug read port
//   branch                take the PC target computed outside this block
//   imm_src, alu_src, alu_ctrl, mem_read, mem_write, mem_2_reg, reg_write,
//   wrt_back_src, second_add_src   datapath controls
//   alu_results/alu_zero/alu_last_bit   ALU result (also memory byte address) and flags
//   mem_rdata             load data (0 unless mem_read)
//   debug_data            mem[debug_addr], valid even in reset
module rv32i_ctrl_alu_dmem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   func3,
  input  logic [6:0]                   func7,
  input  logic [DATA_WIDTH-1:0]        rs1,
  input  logic [DATA_WIDTH-1:0]        rs2,
  input  logic [DATA_WIDTH-1:0]        sign_ext,
  input  logic                         init_done,
  input  logic [DATA_WIDTH-1:0]        init_w_addr,
  input  logic [DATA_WIDTH-1:0]        init_w_dat,
  input  logic                         init_w_enb,
  input  logic [$clog2(MEM_WORDS)-1:0] debug_addr,
  output logic                         branch,
  output logic [2:0]                   imm_src,
  output logic                         alu_src,
  output logic [3:0]                   alu_ctrl,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         mem_2_reg,
  output logic                         reg_write,
  output logic [1:0]                   wrt_back_src,
  output logic [1:0]                   second_add_src,
  output logic [DATA_WIDTH-1:0]        alu_results,
  output logic                         alu_zero,
  output logic                         alu_last_bit,
  output logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic [DATA_WIDTH-1:0]        debug_data
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_U   = 2'b11;

  localparam logic [1:0] SA_LUI   = 2'b00;
  localparam logic [1:0] SA_AUIPC = 2'b01;
  localparam logic [1:0] SA_JALR  = 2'b10;
  localparam logic [1:0] SA_NONE  = 2'b11;

  // func3 -> ALU op for R and I-ALU. SUB only exists in R form (ADDI ignores
  // func7), while SRAI/SRA both use func7[5].
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt,
                                           input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic is_jump;
  logic is_branch;

  // Decoder. Reset simply suppresses decoding so every output sits at its default.
  always_comb begin
    imm_src        = IMM_I;
    alu_src        = 1'b0;
    alu_ctrl       = ALU_ADD;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_2_reg      = 1'b0;
    reg_write      = 1'b0;
    wrt_back_src   = WB_ALU;
    second_add_src = SA_NONE;
    is_jump        = 1'b0;
    is_branch      = 1'b0;
    if (!rst) begin
      case (opcode)
        OP_R: begin
          reg_write = 1'b1;
          alu_ctrl  = f3_to_alu(func3, func7[5], 1'b1);
        end
        OP_I: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = f3_to_alu(func3, func7[5], 1'b0);
        end
        OP_LOAD: begin
          alu_src      = 1'b1;
          mem_read     = 1'b1;
          mem_2_reg    = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = WB_MEM;
        end
        OP_STORE: begin
          alu_src   = 1'b1;
          imm_src   = IMM_S;
          mem_write = 1'b1;
        end
        OP_BRANCH: begin
          imm_src        = IMM_B;
          second_add_src = SA_AUIPC;
          is_branch      = 1'b1;
          // func3[2:1]: 00 eq/ne, 10 signed, 11 unsigned, 01 reserved (never taken)
          case (func3[2:1])
            2'b00:   alu_ctrl = ALU_SUB;
            2'b10:   alu_ctrl = ALU_SLT;
            2'b11:   alu_ctrl = ALU_SLTU;
            default: alu_ctrl = ALU_ADD;
          endcase
        end
        OP_JAL: begin
          is_jump        = 1'b1;
          imm_src        = IMM_J;
          reg_write      = 1'b1;
          wrt_back_src   = WB_PC4;
          second_add_src = SA_AUIPC;
        end
        OP_JALR: begin
          is_jump        = 1'b1;
          alu_src        = 1'b1;
          reg_write      = 1'b1;
          wrt_back_src   = WB_PC4;
          second_add_src = SA_JALR;
        end
        OP_LUI: begin
          imm_src        = IMM_U;
          reg_write      = 1'b1;
          wrt_back_src   = WB_U;
          second_add_src = SA_LUI;
        end
        OP_AUIPC: begin
          imm_src        = IMM_U;
          reg_write      = 1'b1;
          wrt_back_src   = WB_U;
          second_add_src = SA_AUIPC;
        end
        default: ;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            shamt;

  assign op_b  = alu_src ? sign_ext : rs2;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_results = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_results = rs1 + op_b;
      ALU_SUB:  alu_results = rs1 - op_b;
      ALU_AND:  alu_results = rs1 & op_b;
      ALU_OR:   alu_results = rs1 | op_b;
      ALU_XOR:  alu_results = rs1 ^ op_b;
      ALU_SLL:  alu_results = rs1 << shamt;
      ALU_SRL:  alu_results = rs1 >> shamt;
      ALU_SRA:  alu_results = $unsigned($signed(rs1) >>> shamt);
      ALU_SLT:  alu_results[0] = $signed(rs1) < $signed(op_b);
      ALU_SLTU: alu_results[0] = rs1 < op_b;
      default:  alu_results = '0;
    endcase
  end

  assign alu_zero     = (alu_results == '0);
  assign alu_last_bit = alu_results[0];

  // Branch resolution uses the flags of the compare the decoder selected.
  always_comb begin
    branch = is_jump;
    if (is_branch) begin
      case (func3)
        3'b000:         branch = alu_zero;
        3'b001:         branch = !alu_zero;
        3'b100, 3'b110: branch = alu_last_bit;
        3'b101, 3'b111: branch = !alu_last_bit;
        default:        branch = 1'b0;
      endcase
    end
  end

  // Data memory: byte addresses, word granularity, wraps modulo the array size.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_en   = init_done ? mem_write : init_w_enb;
  assign wr_idx  = init_done ? alu_results[AW+1:2] : init_w_addr[AW+1:2];
  assign wr_data = init_done ? rs2 : init_w_dat;

  // No resettable state here: contents survive reset, reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign mem_rdata  = mem_read ? mem[alu_results[AW+1:2]] : '0;
  assign debug_data = mem[debug_addr];

  logic unused_bits;
  assign unused_bits = ^{func7[6], func7[4:0], init_w_addr[DATA_WIDTH-1:AW+2],
                         init_w_addr[1:0]};

endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
module tb_rv32i_ctrl_alu_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1, rs2, sign_ext;
  logic        init_done;
  logic [31:0] init_w_addr, init_w_dat;
  logic        init_w_enb;
  logic [9:0]  debug_addr;
  logic        branch;
  logic [2:0]  imm_src;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        mem_read, mem_write, mem_2_reg, reg_write;
  logic [1:0]  wrt_back_src, second_add_src;
  logic [31:0] alu_results;
  logic        alu_zero, alu_last_bit;
  logic [31:0] mem_rdata, debug_data;

  always #5 clk = ~clk;

  rv32i_ctrl_alu_dmem dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .sign_ext(sign_ext), .init_done(init_done),
    .init_w_addr(init_w_addr), .init_w_dat(init_w_dat), .init_w_enb(init_w_enb),
    .debug_addr(debug_addr), .branch(branch), .imm_src(imm_src), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .reg_write(reg_write), .wrt_back_src(wrt_back_src),
    .second_add_src(second_add_src), .alu_results(alu_results), .alu_zero(alu_zero),
    .alu_last_bit(alu_last_bit), .mem_rdata(mem_rdata), .debug_data(debug_data)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mdl [1024];

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        br, rw, asrc;
    logic [1:0]  wb, sa;
    logic [2:0]  isrc;
  } vec_t;

  typedef struct {
    logic        br, asrc, mr, mw, m2r, rw, known;
    logic [2:0]  isrc;
    logic [3:0]  ctrl;
    logic [1:0]  wb, sa;
    logic [31:0] res, rdata;
  } exp_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, want);
    end
  endtask

  task automatic add_vec(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [3:0] ctrl,
                         input logic [31:0] res, input logic br, input logic rw,
                         input logic asrc, input logic [1:0] wb, input logic [1:0] sa,
                         input logic [2:0] isrc);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.imm = imm;
    v.ctrl = ctrl; v.res = res; v.br = br; v.rw = rw; v.asrc = asrc;
    v.wb = wb; v.sa = sa; v.isrc = isrc;
    vq.push_back(v);
  endtask

  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; sign_ext = imm;
  endtask

  // Reference: instruction semantics straight from the ISA rules.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm);
    exp_t e;
    logic [31:0] rhs;
    e.br = 0; e.asrc = 0; e.mr = 0; e.mw = 0; e.m2r = 0; e.rw = 0; e.known = 1;
    e.isrc = 3'b000; e.ctrl = 4'd0; e.wb = 2'b01; e.sa = 2'b11;
    e.res = a + b; e.rdata = 32'h0;
    case (op)
      7'h33, 7'h13: begin
        e.rw = 1; e.asrc = (op == 7'h13);
        rhs = e.asrc ? imm : b;
        case (f3)
          3'd0: if (op == 7'h33 && f7[5]) begin e.ctrl = 4'd1; e.res = a - rhs; end
                else begin e.ctrl = 4'd0; e.res = a + rhs; end
          3'd1: begin e.ctrl = 4'd5; e.res = a << rhs[4:0]; end
          3'd2: begin e.ctrl = 4'd8; e.res = ($signed(a) < $signed(rhs)) ? 32'd1 : 32'd0; end
          3'd3: begin e.ctrl = 4'd9; e.res = (a < rhs) ? 32'd1 : 32'd0; end
          3'd4: begin e.ctrl = 4'd4; e.res = a ^ rhs; end
          3'd5: if (f7[5]) begin e.ctrl = 4'd7; e.res = $unsigned($signed(a) >>> rhs[4:0]); end
                else begin e.ctrl = 4'd6; e.res = a >> rhs[4:0]; end
          3'd6: begin e.ctrl = 4'd3; e.res = a | rhs; end
          default: begin e.ctrl = 4'd2; e.res = a & rhs; end
        endcase
      end
      7'h03: begin
        e.asrc = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.wb = 2'b00; e.res = a + imm;
        e.rdata = mdl[e.res[11:2]];
      end
      7'h23: begin e.asrc = 1; e.isrc = 3'b001; e.mw = 1; e.res = a + imm; end
      7'h63: begin
        e.isrc = 3'b010; e.sa = 2'b01;
        case (f3)
          3'd0: begin e.ctrl = 4'd1; e.res = a - b; e.br = (a == b); end
          3'd1: begin e.ctrl = 4'd1; e.res = a - b; e.br = (a != b); end
          3'd4: begin e.ctrl = 4'd8; e.br = $signed(a) < $signed(b); e.res = {31'd0, e.br}; end
          3'd5: begin e.ctrl = 4'd8; e.br = $signed(a) >= $signed(b); e.res = {31'd0, !e.br}; end
          3'd6: begin e.ctrl = 4'd9; e.br = a < b; e.res = {31'd0, e.br}; end
          3'd7: begin e.ctrl = 4'd9; e.br = a >= b; e.res = {31'd0, !e.br}; end
          default: e.known = 0;
        endcase
      end
      7'h6F: begin e.br = 1; e.isrc = 3'b011; e.rw = 1; e.wb = 2'b10; e.sa = 2'b01; end
      7'h67: begin
        e.br = 1; e.asrc = 1; e.rw = 1; e.wb = 2'b10; e.sa = 2'b10; e.res = a + imm;
      end
      7'h37: begin e.isrc = 3'b100; e.rw = 1; e.wb = 2'b11; e.sa = 2'b00; end
      7'h17: begin e.isrc = 3'b100; e.rw = 1; e.wb = 2'b11; e.sa = 2'b01; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, " branch"}, branch, e.br);
    chk({tag, " imm_src"}, imm_src, e.isrc);
    chk({tag, " alu_src"}, alu_src, e.asrc);
    chk({tag, " mem_read"}, mem_read, e.mr);
    chk({tag, " mem_write"}, mem_write, e.mw);
    chk({tag, " mem_2_reg"}, mem_2_reg, e.m2r);
    chk({tag, " reg_write"}, reg_write, e.rw);
    chk({tag, " wrt_back_src"}, wrt_back_src, e.wb);
    chk({tag, " second_add_src"}, second_add_src, e.sa);
    chk({tag, " mem_rdata"}, mem_rdata, e.rdata);
    if (e.known) begin
      chk({tag, " alu_ctrl"}, alu_ctrl, e.ctrl);
      chk({tag, " alu_results"}, alu_results, e.res);
      chk({tag, " alu_zero"}, alu_zero, e.res == 32'h0);
      chk({tag, " alu_last_bit"}, alu_last_bit, e.res[0]);
    end
  endtask

  initial begin
    logic [6:0] ops [9];
    exp_t e;
    logic [6:0] op;
    logic [31:0] a, b, imm, d;

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    add_vec("xori",  7'h13, 3'b100, 7'h00, 32'h0F, 32'h0, 32'h05, 4'b0100, 32'h0A, 0, 1, 1, 2'b01, 2'b11, 3'b000);
    add_vec("andi",  7'h13, 3'b111, 7'h00, 32'h0F, 32'h0, 32'h05, 4'b0010, 32'h05, 0, 1, 1, 2'b01, 2'b11, 3'b000);
    add_vec("ori",   7'h13, 3'b110, 7'h00, 32'h0A, 32'h0, 32'h30, 4'b0011, 32'h3A, 0, 1, 1, 2'b01, 2'b11, 3'b000);
    add_vec("beq",   7'h63, 3'b000, 7'h00, 32'h7, 32'h7, 32'h0, 4'b0001, 32'h0, 1, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("bne",   7'h63, 3'b001, 7'h00, 32'h7, 32'h7, 32'h0, 4'b0001, 32'h0, 0, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("blt",   7'h63, 3'b100, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1000, 32'h1, 1, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("bge",   7'h63, 3'b101, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1000, 32'h1, 0, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("bltu",  7'h63, 3'b110, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1001, 32'h0, 0, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("bgeu",  7'h63, 3'b111, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1001, 32'h0, 1, 0, 0, 2'b01, 2'b01, 3'b010);
    add_vec("jal",   7'h6F, 3'b000, 7'h00, 32'h3, 32'h4, 32'h0, 4'b0000, 32'h7, 1, 1, 0, 2'b10, 2'b01, 3'b011);
    add_vec("unk7f", 7'h7F, 3'b000, 7'h00, 32'h3, 32'h4, 32'h0, 4'b0000, 32'h7, 0, 0, 0, 2'b01, 2'b11, 3'b000);
    add_vec("sub",   7'h33, 3'b000, 7'h20, 32'h10, 32'h3, 32'h0, 4'b0001, 32'h0D, 0, 1, 0, 2'b01, 2'b11, 3'b000);
    add_vec("srai",  7'h13, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h404, 4'b0111, 32'hF8000000, 0, 1, 1, 2'b01, 2'b11, 3'b000);
    add_vec("lui",   7'h37, 3'b000, 7'h00, 32'h1, 32'h2, 32'h0, 4'b0000, 32'h3, 0, 1, 0, 2'b11, 2'b00, 3'b100);
    add_vec("auipc", 7'h17, 3'b000, 7'h00, 32'h1, 32'h2, 32'h0, 4'b0000, 32'h3, 0, 1, 0, 2'b11, 2'b01, 3'b100);
    add_vec("jalr",  7'h67, 3'b000, 7'h00, 32'h100, 32'h0, 32'h8, 4'b0000, 32'h108, 1, 1, 1, 2'b10, 2'b10, 3'b000);

    // Reset state
    rst = 1; init_done = 0; init_w_addr = 0; init_w_dat = 0; init_w_enb = 0; debug_addr = 0;
    apply(7'h33, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst R reg_write", reg_write, 1'b0);
    chk("rst R mem_write", mem_write, 1'b0);
    chk("rst R branch", branch, 1'b0);
    chk("rst R mem_rdata", mem_rdata, 32'h0);
    apply(7'h6F, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst jal branch", branch, 1'b0);
    chk("rst jal wrt_back_src", wrt_back_src, 2'b01);
    chk("rst jal second_add_src", second_add_src, 2'b11);
    chk("rst jal imm_src", imm_src, 3'b000);
    apply(7'h03, 3'b010, 7'h00, 32'h0, 32'h0, 32'h4);
    #1;
    chk("rst lw mem_read", mem_read, 1'b0);
    chk("rst lw mem_rdata", mem_rdata, 32'h0);
    apply(7'h33, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
    #1;
    rst = 0;
    #1;
    chk("release reg_write", reg_write, 1'b1);

    // Preload through the init port; a live store aimed at word 512 must be ignored.
    apply(7'h23, 3'b010, 7'h00, 32'h800, 32'h12345678, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      d = (i == 0) ? 32'h0A : (i == 1) ? 32'h05 : $urandom;
      init_w_addr = (i * 4) + (i % 4) + ((i % 3) * 32'h1000);
      init_w_dat  = d;
      init_w_enb  = 1;
      mdl[i] = d;
    end
    @(negedge clk);
    init_w_enb = 0;
    init_w_addr = 32'h14; init_w_dat = 32'h55AA55AA;
    debug_addr = 10'd512;
    #1;
    chk("init store ignored", debug_data, mdl[512]);
    @(negedge clk);
    debug_addr = 10'd5;
    #1;
    chk("init enb=0 blocked", debug_data, mdl[5]);
    debug_addr = 10'd1;
    #1;
    chk("init word1", debug_data, 32'h05);

    // Load after init, same-cycle data
    init_done = 1;
    apply(7'h03, 3'b010, 7'h00, 32'h0, 32'h0, 32'h4);
    #1;
    chk("lw alu_results", alu_results, 32'h4);
    chk("lw mem_rdata", mem_rdata, 32'h05);

    // Store: old value before the edge, new value after
    @(negedge clk);
    apply(7'h23, 3'b010, 7'h00, 32'h8, 32'hDEADBEEF, 32'h0);
    debug_addr = 10'd2;
    #1;
    chk("sw before edge", debug_data, mdl[2]);
    @(posedge clk);
    #1;
    chk("sw after edge", debug_data, 32'hDEADBEEF);
    mdl[2] = 32'hDEADBEEF;
    @(negedge clk);
    apply(7'h7F, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);

    // Reset blocks a store; memory and debug read remain intact
    @(negedge clk);
    rst = 1;
    apply(7'h23, 3'b010, 7'h00, 32'hC, 32'hCAFEF00D, 32'h0);
    debug_addr = 10'd3;
    #1;
    chk("rst store mem_write", mem_write, 1'b0);
    @(posedge clk);
    #1;
    chk("rst store blocked", debug_data, mdl[3]);
    @(negedge clk);
    rst = 0;
    apply(7'h7F, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);

    // Directed table
    foreach (vq[i]) begin
      @(negedge clk);
      apply(vq[i].op, vq[i].f3, vq[i].f7, vq[i].a, vq[i].b, vq[i].imm);
      #1;
      chk({vq[i].name, " alu_ctrl"}, alu_ctrl, vq[i].ctrl);
      chk({vq[i].name, " alu_results"}, alu_results, vq[i].res);
      chk({vq[i].name, " branch"}, branch, vq[i].br);
      chk({vq[i].name, " reg_write"}, reg_write, vq[i].rw);
      chk({vq[i].name, " alu_src"}, alu_src, vq[i].asrc);
      chk({vq[i].name, " wrt_back_src"}, wrt_back_src, vq[i].wb);
      chk({vq[i].name, " second_add_src"}, second_add_src, vq[i].sa);
      chk({vq[i].name, " imm_src"}, imm_src, vq[i].isrc);
    end

    // Randomized against the reference model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 9) begin
        op = 7'($urandom);
        foreach (ops[k]) if (ops[k] == op) op = 7'h7F;
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3)) - 32'd2;
      imm = $urandom;
      apply(op, 3'($urandom), $urandom_range(0, 1) ? 7'h20 : 7'h00, a, b, imm);
      debug_addr = 10'($urandom);
      #1;
      e = model(opcode, func3, func7, a, b, imm);
      check_all($sformatf("rnd%0d op=%02h f3=%0d", i, op, func3), e);
      chk($sformatf("rnd%0d debug_data", i), debug_data, mdl[debug_addr]);
      @(posedge clk);
      if (op == 7'h23) mdl[e.res[11:2]] = b;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_alu_dmem.md
# rv32i_ctrl_alu_dmem

Combinational control decoder, ALU and 4 KiB word-addressed data memory for the single-cycle RV32I core. Decodes opcode/func3/func7 into datapath controls and branch decisions, executes the ALU operation, and serves load/store traffic. A separate initialisation write port preloads data before execution. Fetch, PC, register file and sign extension sit outside this block.

## Interface
- DATA_WIDTH, 32, data and address width
- MEM_WORDS, 1024, data memory depth in 32-bit words
- clk  in  1  clock; memory writes on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0]
- func3  in  3  instr[14:12]
- func7  in  7  instr[31:25]
- rs1, rs2  in  32  register file read data
- sign_ext  in  32  sign-extended immediate
- init_done  in  1  0: init port drives memory write; 1: store path drives it
- init_w_addr  in  32  init write byte address
- init_w_dat  in  32  init write data
- init_w_enb  in  1  init write enable
- debug_addr  in  10  debug read word index
- branch  out  1  take PC target
- imm_src  out  3  I=000, S=001, B=010, J=011, U=100
- alu_src  out  1  0: operand B = rs2; 1: sign_ext
- alu_ctrl  out  4  ALU operation code
- mem_read, mem_write, mem_2_reg, reg_write  out  1 each
- wrt_back_src  out  2  MEM=00, ALU=01, PC+4=10, U-type=11
- second_add_src  out  2  LUI=00, AUIPC=01, JALR=10, NONE=11
- alu_results  out  32  ALU result; also memory byte address
- alu_zero  out  1  alu_results == 0
- alu_last_bit  out  1  alu_results[0]
- mem_rdata  out  32  load data
- debug_data  out  32  mem[debug_addr]

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000 (signed), SLTU 1001; others yield 0. Shift amount = B[4:0]. SLT/SLTU give 1/0.
- func3 map (R and I-ALU): 000 ADD (SUB if R and func7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by func7[5], 110 OR, 111 AND.
- Defaults: all 1-bit outputs 0, imm_src 000, alu_ctrl ADD, wrt_back_src 01, second_add_src 11.
- 0110011 R: reg_write=1, alu_src=0.
- 0010011 I-ALU: reg_write=1, alu_src=1, imm_src I.
- 0000011 load: ADD, alu_src=1, mem_read=1, mem_2_reg=1, reg_write=1, wrt_back_src 00; word access regardless of func3.
- 0100011 store: ADD, alu_src=1, imm_src S, mem_write=1; word access.
- 1100011 branch: alu_src=0, imm_src B, second_add_src AUIPC; beq SUB & zero; bne SUB & !zero; blt SLT & last_bit; bge SLT & !last_bit; bltu/bgeu same with SLTU; func3 010/011 never branch.
- 1101111 jal: branch=1, imm_src J, reg_write=1, wrt_back_src 10, second_add_src AUIPC.
- 1100111 jalr: branch=1, imm_src I, alu_src=1, reg_write=1, wrt_back_src 10, second_add_src JALR.
- 0110111 lui / 0010111 auipc: imm_src U, reg_write=1, wrt_back_src 11, second_add_src LUI / AUIPC.
- Unknown opcode: defaults (no writes, no branch).
- Memory: word index = addr[11:2]; addr[1:0] ignored; addresses wrap modulo 4 KiB. Write source = init port when init_done=0, else (alu_results, rs2, mem_write).
- mem_rdata = mem[alu_results[11:2]] when mem_read=1, else 0.

## Timing
- Control, ALU, mem_rdata, debug_data fully combinational.
- Write lands on rising clk edge when selected enable=1 and rst=0; visible on reads immediately after that edge.
- Same-address read during write: old data before edge, new after.
- rst=1 (asynchronous, any time): all control outputs forced to defaults, mem_rdata=0, writes blocked; memory contents retained; debug_data still valid.
- Release of rst: outputs follow inputs combinationally, no latency.

## Test plan
- rst=1 with opcode 0110011 -> reg_write=0, mem_write=0, branch=0, mem_rdata=0; release -> reg_write=1.
- XORI rs1=0x0F, imm=0x05 -> alu_ctrl 0100, alu_results 0x0A; ANDI -> 0x05; ORI 0x0A|0x30 -> 0x3A; all reg_write=1, alu_src=1, wrt_back_src 01.
- init_done=0, init writes 0x0A@0, 0x05@4; init_done=1; lw rs1=0, imm=4 -> alu_results 4, mem_rdata 0x05 same cycle.
- sw rs1=8, imm=0, rs2=0xDEADBEEF: before edge debug_addr=2 gives old value; after edge 0xDEADBEEF.
- beq rs1=rs2=7 -> branch=1; bne -> 0; blt rs1=0xFFFFFFFF, rs2=1 -> 1; bltu same -> 0.
- jal -> branch=1, wrt_back_src 10, second_add_src 01; unknown opcode 0x7F -> all defaults.
